// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, data words and pipeline controller states.
package cpu_types_pkg;

   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline controller bundle: hazard inputs from the datapath and per-register enables/flushes.
interface pipeline_ctrl_if
   import cpu_types_pkg::*;
#(
   parameter int STALL_W = 32
);
   logic               ihit, dhit;
   logic               mem_dREN, mem_dWEN, mem_halt;
   logic               ex_dREN;
   regbits_t           ex_writeReg, id_rs, id_rt;
   logic               id_usesRt, branch_taken;
   logic               pcWEN;
   logic               ifid_writeEN, ifid_flush;
   logic               idex_writeEN, idex_flush;
   logic               exmem_writeEN, exmem_flush;
   logic               memwb_writeEN, memwb_flush;
   logic               halt;
   logic [STALL_W-1:0] stall_cnt;

   modport pc (
      input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN,
             ex_writeReg, id_rs, id_rt, id_usesRt, branch_taken,
      output pcWEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
             exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush,
             halt, stall_cnt
   );

   modport dp (
      output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN,
             ex_writeReg, id_rs, id_rt, id_usesRt, branch_taken,
      input  pcWEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
             exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush,
             halt, stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: enables/flushes are combinational from state and hazards (zero latency);
// memory waits freeze everything, fetch misses bubble MEM, load-use inserts one ID/EX bubble.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int STALL_W = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ihit,
   input  logic               dhit,
   input  logic               mem_dREN,
   input  logic               mem_dWEN,
   input  logic               mem_halt,
   input  logic               ex_dREN,
   input  logic [4:0]         ex_writeReg,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic               id_usesRt,
   input  logic               branch_taken,
   output logic               pcWEN,
   output logic               ifid_writeEN,
   output logic               ifid_flush,
   output logic               idex_writeEN,
   output logic               idex_flush,
   output logic               exmem_writeEN,
   output logic               exmem_flush,
   output logic               memwb_writeEN,
   output logic               memwb_flush,
   output logic               halt,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam logic [STALL_W-1:0] CNT_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   pctrl_state_t state, next_state;
   logic         dacc, lu, active, back_go, fgo;
   regbits_t     ex_dst;

   assign ex_dst = ex_writeReg;
   assign dacc   = mem_dREN | mem_dWEN;
   assign lu     = ex_dREN && (ex_dst != '0) &&
                   ((ex_dst == id_rs) || (id_usesRt && (ex_dst == id_rt)));

   always_comb begin
      next_state = state;
      active     = 1'b0;
      back_go    = 1'b0;
      case (state)
         RUN: begin
            if (dacc && !dhit) begin
               next_state = DWAIT;
            end else begin
               active  = 1'b1;
               back_go = dacc ? 1'b1 : ihit;
            end
         end
         DWAIT: begin
            if (dhit) begin
               next_state = RUN;
               active     = 1'b1;
               back_go    = 1'b1;
            end
         end
         HALT:    next_state = HALT;
         default: next_state = RUN;
      endcase
      if (active && back_go && mem_halt)
         next_state = HALT;
   end

   assign fgo = active && back_go && ihit;

   always_comb begin
      pcWEN         = 1'b0;
      ifid_writeEN  = 1'b0;
      ifid_flush    = 1'b0;
      idex_writeEN  = 1'b0;
      idex_flush    = 1'b0;
      exmem_writeEN = 1'b0;
      exmem_flush   = 1'b0;
      memwb_writeEN = 1'b0;
      memwb_flush   = 1'b0;
      if (active) begin
         exmem_writeEN = back_go;
         memwb_writeEN = back_go;
         exmem_flush   = back_go && !ihit;
         if (fgo) begin
            pcWEN        = 1'b1;
            ifid_writeEN = 1'b1;
            idex_writeEN = 1'b1;
            if (branch_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (lu) begin
               pcWEN        = 1'b0;
               ifid_writeEN = 1'b0;
               idex_flush   = 1'b1;
            end
         end
         // HALT drains only into MEM/WB; everything upstream is squashed and the PC frozen.
         if (back_go && mem_halt) begin
            pcWEN         = 1'b0;
            ifid_writeEN  = 1'b0;
            idex_writeEN  = 1'b0;
            exmem_writeEN = 1'b0;
            memwb_writeEN = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         stall_cnt <= '0;
      end else begin
         state <= next_state;
         if ((state != HALT) && !pcWEN && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   assign halt = (state == HALT);

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the `writeEN`/`flush` pair of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves instruction-fetch waits, data-memory waits, load-use bubbles, taken-branch squashes and halt shutdown. A small Mealy FSM tracks outstanding data accesses and the halted state, and a saturating counter reports lost fetch cycles.

## Interface
Parameters:
- `STALL_W`, 32: width of the stall counter.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `ihit` in 1: instruction memory returns a valid word this cycle.
- `dhit` in 1: data memory completes the MEM-stage access this cycle.
- `mem_dREN` in 1: the instruction in EX/MEM is a load.
- `mem_dWEN` in 1: the instruction in EX/MEM is a store.
- `mem_halt` in 1: the instruction in EX/MEM is HALT.
- `ex_dREN` in 1: the instruction in ID/EX is a load.
- `ex_writeReg` in 5: destination register of the ID/EX instruction.
- `id_rs` in 5: source select of the IF/ID instruction.
- `id_rt` in 5: source select of the IF/ID instruction.
- `id_usesRt` in 1: the IF/ID instruction reads `rt`.
- `branch_taken` in 1: EX stage resolved a redirect (taken branch, J, JAL, JR).
- `pcWEN` out 1: PC register update enable.
- `ifid_writeEN` out 1, `ifid_flush` out 1: IF/ID register controls.
- `idex_writeEN` out 1, `idex_flush` out 1: ID/EX register controls.
- `exmem_writeEN` out 1, `exmem_flush` out 1: EX/MEM register controls.
- `memwb_writeEN` out 1, `memwb_flush` out 1: MEM/WB register controls.
- `halt` out 1: registered and sticky; the core has stopped.
- `stall_cnt` out `STALL_W`: saturating count of cycles with `pcWEN`=0 while not halted.

## Operation
- States: RUN, DWAIT, HALT. Reset state is RUN.
- Derived signals:
  - `dacc` = `mem_dREN` | `mem_dWEN`.
  - `lu` = `ex_dREN` & (`ex_writeReg`≠0) & (`ex_writeReg`==`id_rs` | (`id_usesRt` & `ex_writeReg`==`id_rt`)).
- Default: every output 0. The register module gives `flush` priority over `writeEN`.
- RUN, `dacc` & !`dhit`: all enables 0 (full freeze). Next state DWAIT.
- RUN, !`dacc` or `dhit`, with `back_go`=1 if `dacc` else `ihit`:
  - `exmem_writeEN` = `memwb_writeEN` = `back_go`.
  - Front advance `fgo` = `back_go` & `ihit`.
  - If `back_go` & !`ihit`: `exmem_flush`=1, so a bubble enters MEM and the front holds.
  - If `fgo`: `pcWEN` = `ifid_writeEN` = `idex_writeEN` = 1, then apply the overrides in priority order:
    1. `branch_taken`: `ifid_flush`=1, `idex_flush`=1; `pcWEN` stays 1 to load the target.
    2. else `lu`: `pcWEN`=0, `ifid_writeEN`=0, `idex_flush`=1 (one bubble).
  - If `mem_halt` & `back_go`: `memwb_writeEN`=1, `exmem_flush`=1, `idex_flush`=1, `ifid_flush`=1, `pcWEN`=0. Next state HALT. This overrides everything except the MEM/WB capture.
- DWAIT: full freeze until `dhit`. On the `dhit` cycle, apply the RUN rules with `back_go`=1, then return to RUN. `ihit` may be asserted on that cycle.
- HALT: all enables and flushes 0; `halt`=1. Only `RST` leaves this state.
- `stall_cnt` increments in RUN/DWAIT when `pcWEN`=0 and saturates at all-ones. It holds in HALT.

## Timing
- All enable/flush outputs are combinational from state and inputs; there is no added latency. Pipeline registers act on the same edge.
- `halt` rises on the edge after the cycle HALT is chosen, i.e. the cycle after the HALT instruction is captured into MEM/WB.
- Load-use costs exactly one cycle; the consumer advances on the next `ihit`.
- Simultaneous `branch_taken` & `lu`: the branch wins and there is no bubble. The load-use consumer is squashed.
- Simultaneous `mem_halt` & `branch_taken`: the halt wins.
- `dhit` without `dacc` is ignored.
- `RST` asserted at any time, including mid-DWAIT: state RUN, `halt`=0, `stall_cnt`=0 immediately. Combinational outputs follow RUN rules while `RST` is high.

## Structure
- Add `pctrl_state_t` (RUN=2'd0, DWAIT=2'd1, HALT=2'd2) to `cpu_types_pkg`. Reuse `regbits_t` and `word_t`.
- Single module with no sub-modules. The load-use comparator stays inline.
- The `pipeline_ctrl_if` interface carries all ports except `CLK`/`RST`, in the same style as the existing pipeline register interfaces.

## Test plan
- Reset pulse mid-DWAIT with `dacc`=1, `dhit`=0 → state RUN, `halt`=0, `stall_cnt`=0; with `ihit`=1 and `dacc`=0 the next cycle, all `writeEN`=1.
- `dacc`=1, `dhit`=0 for 3 cycles, then `dhit`=1 with `ihit`=0 → 3 freeze cycles, then `exmem_flush`=1, `memwb_writeEN`=1, `pcWEN`=0; `stall_cnt`=4.
- `ex_dREN`=1, `ex_writeReg`=5, `id_rs`=5, `ihit`=1 → `pcWEN`=0, `ifid_writeEN`=0, `idex_flush`=1 for one cycle; repeat with `ex_writeReg`=0 → no bubble.
- `branch_taken`=1 together with the load-use condition above, `ihit`=1 → `ifid_flush`=1, `idex_flush`=1, `pcWEN`=1, no stall count.
- `mem_halt`=1, `ihit`=1 → `memwb_writeEN`=1 and all upstream flushes that cycle; `halt`=1 next edge; further `ihit`/`dhit` change no output.
- Force `stall_cnt` near saturation (`STALL_W`=4, 16 `ihit`=0 cycles) → holds at 15.
